// File: rtl/perf_dump_unit.sv
// perf_dump_unit: per-event performance counters, global cycle count, log window
// and a valid/ready snapshot stream of the counters (periodic or on request).
`timescale 1ns/1ps

module perf_dump_unit #(
  parameter int unsigned EVENT_NUM     = 8,
  parameter int unsigned CNT_WIDTH     = 32,
  parameter int unsigned DUMP_INTERVAL = 100000,
  parameter int unsigned LOG_START     = 0,
  parameter int unsigned LOG_END       = 0,
  localparam int unsigned ID_W         = (EVENT_NUM > 1) ? $clog2(EVENT_NUM) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EVENT_NUM-1:0] events,
  input  logic                 dump_req,
  output logic [63:0]          cycle_cnt,
  output logic                 log_valid,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [ID_W-1:0]      dump_id,
  output logic [CNT_WIDTH-1:0] dump_count,
  output logic                 dump_last,
  output logic                 busy
);

  localparam int unsigned TMR_W = (DUMP_INTERVAL > 1) ? $clog2(DUMP_INTERVAL) : 1;
  localparam logic [ID_W-1:0]      LAST_ID  = ID_W'(EVENT_NUM - 1);
  localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'((DUMP_INTERVAL > 0) ? (DUMP_INTERVAL - 1) : 0);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q    [EVENT_NUM];
  logic [CNT_WIDTH-1:0]   shadow_q [EVENT_NUM];
  logic [TMR_W-1:0]       timer_q;
  logic                   pending_q, pending_d;
  logic [ID_W-1:0]        id_d;
  logic                   capture;
  logic                   valid_d;
  logic                   last_d;
  logic [CNT_WIDTH-1:0]   count_d;
  logic                   auto_trig;
  logic                   trigger;

  // Free-running cycle counter, wraps modulo 2^64.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cycle_cnt <= '0;
    else      cycle_cnt <= cycle_cnt + 64'(1);
  end

  // Logging window decoded straight off the cycle counter; held low in reset.
  assign log_valid = rst
                   && (cycle_cnt >= 64'(LOG_START))
                   && ((LOG_END == 0) || (cycle_cnt < 64'(LOG_END)));

  // Interval timer for automatic dumps; runs independently of the dump FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         timer_q <= '0;
    else if ((DUMP_INTERVAL <= 1) || (timer_q == TMR_LAST)) timer_q <= '0;
    else                                              timer_q <= timer_q + TMR_W'(1);
  end

  assign auto_trig = (DUMP_INTERVAL != 0) && (timer_q == TMR_LAST);
  assign trigger   = auto_trig || dump_req;

  for (genvar g = 0; g < EVENT_NUM; g++) begin : g_cnt
    // Saturating per-event counter; never cleared by a dump.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                  cnt_q[g] <= '0;
      else if (events[g] && (cnt_q[g] != CNT_MAX)) cnt_q[g] <= cnt_q[g] + CNT_WIDTH'(1);
    end

    // Snapshot takes the registered count, excluding this cycle's event.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)         shadow_q[g] <= '0;
      else if (capture) shadow_q[g] <= cnt_q[g];
    end
  end

  // Dump FSM next-state, pending coalescing and next output values.
  always_comb begin
    state_d   = state_q;
    id_d      = dump_id;
    pending_d = pending_q;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger || pending_q) begin
          capture   = 1'b1;
          id_d      = '0;
          pending_d = 1'b0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (trigger) pending_d = 1'b1;
        if (dump_ready) begin
          if (dump_id == LAST_ID) state_d = IDLE;
          else                    id_d    = dump_id + ID_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == SEND);
    last_d  = valid_d && (id_d == LAST_ID);
    count_d = capture ? cnt_q[0] : shadow_q[id_d];
  end

  // FSM state and registered dump outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      dump_id    <= '0;
      dump_valid <= 1'b0;
      busy       <= 1'b0;
      dump_last  <= 1'b0;
      dump_count <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      dump_id    <= id_d;
      dump_valid <= valid_d;
      busy       <= valid_d;
      dump_last  <= last_d;
      dump_count <= count_d;
    end
  end

endmodule

// File: tb/tb_perf_dump_unit.sv
// Directed self-checking bench for perf_dump_unit (two configurations).
`timescale 1ns/1ps

module tb_perf_dump_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 4 events, 8-bit counters, no auto dump, log window 0..4.
  logic        rst_a = 1'b0;
  logic [3:0]  ev_a  = '0;
  logic        req_a = 1'b0;
  logic        rdy_a = 1'b1;
  logic [63:0] cyc_a;
  logic        logv_a, val_a, last_a, busy_a;
  logic [1:0]  id_a;
  logic [7:0]  cnt_a;

  // Instance B: 4 events, 4-bit counters, auto dump every 20 cycles.
  logic        rst_b = 1'b0;
  logic [3:0]  ev_b  = '0;
  logic        req_b = 1'b0;
  logic        rdy_b = 1'b1;
  logic [63:0] cyc_b;
  logic        logv_b, val_b, last_b, busy_b;
  logic [1:0]  id_b;
  logic [3:0]  cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  perf_dump_unit #(.EVENT_NUM(4), .CNT_WIDTH(8), .DUMP_INTERVAL(0),
                   .LOG_START(0), .LOG_END(5)) dut_a (
    .clk(clk), .rst(rst_a), .events(ev_a), .dump_req(req_a),
    .cycle_cnt(cyc_a), .log_valid(logv_a), .dump_valid(val_a),
    .dump_ready(rdy_a), .dump_id(id_a), .dump_count(cnt_a),
    .dump_last(last_a), .busy(busy_a)
  );

  perf_dump_unit #(.EVENT_NUM(4), .CNT_WIDTH(4), .DUMP_INTERVAL(20),
                   .LOG_START(0), .LOG_END(0)) dut_b (
    .clk(clk), .rst(rst_b), .events(ev_b), .dump_req(req_b),
    .cycle_cnt(cyc_b), .log_valid(logv_b), .dump_valid(val_b),
    .dump_ready(rdy_b), .dump_id(id_b), .dump_count(cnt_b),
    .dump_last(last_b), .busy(busy_b)
  );

  task automatic test_reset();
    rst_a = 1'b0;
    @(negedge clk); @(negedge clk);
    n_tests++; if (cyc_a !== 64'd0) begin n_fail++; $display("FAIL reset_cycle_cnt got %0d want 0", cyc_a); end
    n_tests++; if (logv_a !== 1'b0) begin n_fail++; $display("FAIL reset_log_valid got %b want 0", logv_a); end
    n_tests++; if (val_a !== 1'b0) begin n_fail++; $display("FAIL reset_dump_valid got %b want 0", val_a); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_a); end
    n_tests++; if (last_a !== 1'b0) begin n_fail++; $display("FAIL reset_dump_last got %b want 0", last_a); end
    n_tests++; if (id_a !== 2'd0) begin n_fail++; $display("FAIL reset_dump_id got %0d want 0", id_a); end
    n_tests++; if (cnt_a !== 8'd0) begin n_fail++; $display("FAIL reset_dump_count got %0d want 0", cnt_a); end
    rst_a = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (cyc_a !== 64'(i)) begin n_fail++; $display("FAIL cycle_cnt[%0d] got %0d want %0d", i, cyc_a, i); end
      n_tests++;
      if (logv_a !== (i < 5)) begin n_fail++; $display("FAIL log_valid[%0d] got %b want %b", i, logv_a, (i < 5)); end
      @(negedge clk);
    end
  endtask

  task automatic test_count();
    logic [7:0] exp_c [4];
    exp_c = '{8'd10, 8'd0, 8'd10, 8'd0};
    rdy_a = 1'b1;
    ev_a  = 4'b0101;
    repeat (10) @(negedge clk);
    ev_a  = 4'b0000;
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    for (int b = 0; b < 4; b++) begin
      n_tests++; if (val_a !== 1'b1) begin n_fail++; $display("FAIL count_valid beat %0d got %b want 1", b, val_a); end
      n_tests++; if (id_a !== 2'(b)) begin n_fail++; $display("FAIL count_id beat %0d got %0d want %0d", b, id_a, b); end
      n_tests++; if (cnt_a !== exp_c[b]) begin n_fail++; $display("FAIL count_value beat %0d got %0d want %0d", b, cnt_a, exp_c[b]); end
      n_tests++; if (last_a !== (b == 3)) begin n_fail++; $display("FAIL count_last beat %0d got %b want %b", b, last_a, (b == 3)); end
      n_tests++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL count_busy beat %0d got %b want 1", b, busy_a); end
      @(negedge clk);
    end
    n_tests++; if (val_a !== 1'b0) begin n_fail++; $display("FAIL count_done_valid got %b want 0", val_a); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL count_done_busy got %b want 0", busy_a); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_c [4];
    int idx;
    int k;
    exp_c = '{8'd10, 8'd3, 8'd10, 8'd0};
    ev_a = 4'b0010;
    repeat (3) @(negedge clk);
    ev_a  = 4'b0000;
    rdy_a = 1'b0;
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    idx = 0;
    k   = 0;
    while (idx < 4 && k < 20) begin
      rdy_a = (k % 2 == 1);
      n_tests++; if (val_a !== 1'b1) begin n_fail++; $display("FAIL bp_valid cycle %0d got %b want 1", k, val_a); end
      n_tests++; if (id_a !== 2'(idx)) begin n_fail++; $display("FAIL bp_id cycle %0d got %0d want %0d", k, id_a, idx); end
      n_tests++; if (cnt_a !== exp_c[idx]) begin n_fail++; $display("FAIL bp_count cycle %0d got %0d want %0d", k, cnt_a, exp_c[idx]); end
      n_tests++; if (last_a !== (idx == 3)) begin n_fail++; $display("FAIL bp_last cycle %0d got %b want %b", k, last_a, (idx == 3)); end
      if (rdy_a) idx++;
      k++;
      @(negedge clk);
    end
    rdy_a = 1'b1;
    n_tests++; if (idx !== 4) begin n_fail++; $display("FAIL bp_timeout beats got %0d want 4", idx); end
    n_tests++; if (val_a !== 1'b0) begin n_fail++; $display("FAIL bp_done_valid got %b want 0", val_a); end
  endtask

  task automatic test_pending();
    logic [7:0] exp1 [4];
    logic [7:0] exp2 [4];
    exp1 = '{8'd10, 8'd3, 8'd10, 8'd2};
    exp2 = '{8'd11, 8'd3, 8'd10, 8'd2};
    rdy_a = 1'b1;
    ev_a  = 4'b1000;
    repeat (2) @(negedge clk);
    ev_a  = 4'b0000;
    req_a = 1'b1;
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      req_a = (b >= 1);
      ev_a  = (b == 0) ? 4'b0001 : 4'b0000;
      n_tests++; if (val_a !== 1'b1) begin n_fail++; $display("FAIL pend1_valid beat %0d got %b want 1", b, val_a); end
      n_tests++; if (id_a !== 2'(b)) begin n_fail++; $display("FAIL pend1_id beat %0d got %0d want %0d", b, id_a, b); end
      n_tests++; if (cnt_a !== exp1[b]) begin n_fail++; $display("FAIL pend1_count beat %0d got %0d want %0d", b, cnt_a, exp1[b]); end
      @(negedge clk);
    end
    req_a = 1'b0;
    ev_a  = 4'b0000;
    n_tests++; if (val_a !== 1'b0) begin n_fail++; $display("FAIL pend_bubble_valid got %b want 0", val_a); end
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      n_tests++; if (val_a !== 1'b1) begin n_fail++; $display("FAIL pend2_valid beat %0d got %b want 1", b, val_a); end
      n_tests++; if (id_a !== 2'(b)) begin n_fail++; $display("FAIL pend2_id beat %0d got %0d want %0d", b, id_a, b); end
      n_tests++; if (cnt_a !== exp2[b]) begin n_fail++; $display("FAIL pend2_count beat %0d got %0d want %0d", b, cnt_a, exp2[b]); end
      @(negedge clk);
    end
    for (int c = 0; c < 4; c++) begin
      n_tests++; if (val_a !== 1'b0) begin n_fail++; $display("FAIL pend_coalesce cycle %0d valid got %b want 0", c, val_a); end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    rdy_a = 1'b1;
    ev_a  = 4'b1111;
    repeat (2) @(negedge clk);
    ev_a  = 4'b0000;
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk); @(negedge clk);
    n_tests++; if (id_a !== 2'd2) begin n_fail++; $display("FAIL mid_pre_id got %0d want 2", id_a); end
    rst_a = 1'b0;
    #1;
    n_tests++; if (val_a !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", val_a); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", busy_a); end
    n_tests++; if (cnt_a !== 8'd0) begin n_fail++; $display("FAIL mid_count got %0d want 0", cnt_a); end
    n_tests++; if (id_a !== 2'd0) begin n_fail++; $display("FAIL mid_id got %0d want 0", id_a); end
    n_tests++; if (cyc_a !== 64'd0) begin n_fail++; $display("FAIL mid_cycle_cnt got %0d want 0", cyc_a); end
    n_tests++; if (logv_a !== 1'b0) begin n_fail++; $display("FAIL mid_log_valid got %b want 0", logv_a); end
    @(negedge clk); @(negedge clk);
    rst_a = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++; if (val_a !== 1'b0) begin n_fail++; $display("FAIL mid_no_dump cycle %0d got %b want 0", c, val_a); end
    end
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    for (int b = 0; b < 4; b++) begin
      n_tests++; if (val_a !== 1'b1) begin n_fail++; $display("FAIL mid_redump_valid beat %0d got %b want 1", b, val_a); end
      n_tests++; if (id_a !== 2'(b)) begin n_fail++; $display("FAIL mid_redump_id beat %0d got %0d want %0d", b, id_a, b); end
      n_tests++; if (cnt_a !== 8'd0) begin n_fail++; $display("FAIL mid_redump_count beat %0d got %0d want 0", b, cnt_a); end
      @(negedge clk);
    end
  endtask

  task automatic test_auto_saturate();
    logic       exp_v;
    logic [1:0] exp_id;
    logic [3:0] exp_cnt;
    ev_b  = 4'b0001;
    rdy_b = 1'b1;
    req_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    for (int c = 0; c < 45; c++) begin
      exp_v   = ((c >= 20) && (c < 24)) || ((c >= 40) && (c < 44));
      exp_id  = 2'(c % 20);
      exp_cnt = (exp_id == 2'd0) ? 4'd15 : 4'd0;
      n_tests++; if (cyc_b !== 64'(c)) begin n_fail++; $display("FAIL auto_cycle_cnt got %0d want %0d", cyc_b, c); end
      n_tests++; if (logv_b !== 1'b1) begin n_fail++; $display("FAIL auto_log_valid cycle %0d got %b want 1", c, logv_b); end
      n_tests++; if (val_b !== exp_v) begin n_fail++; $display("FAIL auto_valid cycle %0d got %b want %b", c, val_b, exp_v); end
      n_tests++; if (busy_b !== exp_v) begin n_fail++; $display("FAIL auto_busy cycle %0d got %b want %b", c, busy_b, exp_v); end
      if (exp_v) begin
        n_tests++; if (id_b !== exp_id) begin n_fail++; $display("FAIL auto_id cycle %0d got %0d want %0d", c, id_b, exp_id); end
        n_tests++; if (cnt_b !== exp_cnt) begin n_fail++; $display("FAIL auto_count cycle %0d got %0d want %0d", c, cnt_b, exp_cnt); end
        n_tests++; if (last_b !== (exp_id == 2'd3)) begin n_fail++; $display("FAIL auto_last cycle %0d got %b want %b", c, last_b, (exp_id == 2'd3)); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count();
    test_backpressure();
    test_pending();
    test_mid_reset();
    test_auto_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_dump_unit.md
# perf_dump_unit

Central performance-event collector and log-window controller for the core's simulation/debug infrastructure. It accumulates per-event counters from pipeline event pulses and supplies the global cycle count and log-enable window that gate every logging site. It also streams counter snapshots, periodically or on request, over a valid/ready port to the downstream difftest/log sink. The block is purely observational and never back-pressures the pipeline.

## Interface
Parameters:
- EVENT_NUM, 8: number of event inputs (≥1).
- CNT_WIDTH, 32: per-event counter width.
- DUMP_INTERVAL, 100000: cycles between automatic dumps; 0 disables automatic dumps.
- LOG_START, 0: first cycle_cnt value at which log_valid is high.
- LOG_END, 0: cycle_cnt value at which log_valid drops; 0 means never.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset (`RST` = 0).
- events  in  EVENT_NUM  per-cycle event pulses; bit i counts into counter i.
- dump_req  in  1  manual dump trigger, sampled each cycle.
- cycle_cnt  out  64  cycles since reset release.
- log_valid  out  1  logging window active.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  sink accepts beat.
- dump_id  out  $clog2(EVENT_NUM) (min 1)  event index of current beat.
- dump_count  out  CNT_WIDTH  snapshot value of counter dump_id.
- dump_last  out  1  current beat is index EVENT_NUM-1.
- busy  out  1  FSM in SEND.

## Operation
- Counter reset values: cycle_cnt, all counters, interval timer, shadow registers, dump_id, and pending are all 0. The FSM resets to IDLE, so dump_valid, busy, and dump_last reset to 0.
- cycle_cnt increments by 1 every cycle after reset release and wraps modulo 2^64.
- log_valid is combinational on the cycle_cnt register: (cycle_cnt ≥ LOG_START) && (LOG_END==0 || cycle_cnt < LOG_END). It is forced to 0 while rst is low.
- Counter i increments by 1 in any cycle where events[i]=1, and saturates at all-ones (it never wraps). Counters are cumulative and are never cleared by a dump.
- Interval timer counts 0..DUMP_INTERVAL-1 and wraps. An auto trigger fires in the cycle the timer equals DUMP_INTERVAL-1. The timer runs regardless of FSM state.
- trigger = auto trigger || dump_req.
- FSM states:
  - IDLE: if trigger or pending, capture the snapshot, set dump_id=0, clear pending, and go to SEND.
  - SEND: dump_valid=1. On dump_valid&&dump_ready: if dump_id==EVENT_NUM-1, go to IDLE; otherwise dump_id+1.
- Snapshot: shadow[i] takes counter i's value as registered at the start of the trigger cycle. The same-cycle event increments go to the live counter only, not the shadow.
- Triggers arriving while in SEND set pending. Multiple triggers coalesce into one pending dump. A trigger arriving in the same cycle as the final handshake also sets pending.
- dump_count = shadow[dump_id], and is held stable while dump_valid && !dump_ready.
- dump_last = SEND && dump_id==EVENT_NUM-1.
- Reset asserted mid-dump aborts the dump immediately. All state returns to reset values and no beat is completed.

## Timing
- Trigger in cycle t while in IDLE: dump_valid=1 with dump_id=0 in cycle t+1.
- Throughput is one beat per cycle with dump_ready held high, so a dump takes EVENT_NUM cycles.
- After the final handshake in cycle u, the FSM is IDLE in u+1. If pending is set, dump_valid rises again in u+2, giving a minimum 1-cycle bubble.
- Counter and cycle_cnt updates are visible one cycle after the event.
- log_valid follows cycle_cnt with zero added latency: first high in the cycle where cycle_cnt==LOG_START, first low when cycle_cnt==LOG_END.

## Test plan
- Reset behaviour with LOG_START=0, LOG_END=5: hold rst low, then release. Required: cycle_cnt reads 0,1,2,… and log_valid is high for cycle_cnt 0–4, low from 5.
- Event counting with EVENT_NUM=4: drive events=4'b0101 for 10 cycles, then pulse dump_req with dump_ready=1. Required: 4 beats with ids 0..3 and counts 10,0,10,0, dump_last only on id 3.
- Backpressure: toggle dump_ready 1/0 during a dump. Required: id and count held while ready=0, no beat skipped or duplicated.
- Pending and coalescing: pulse dump_req 3 times during a dump. Required: exactly one extra dump follows, with dump_valid rising 2 cycles after the final handshake of the first dump.
- Saturation and auto dump with CNT_WIDTH=4, DUMP_INTERVAL=20: hold events[0]=1. Required: counter 0 sticks at 15, and an auto dump starts at cycle_cnt 20 (trigger in cycle 19) reporting 15.
- Mid-dump reset: assert rst during beat 2. Required: dump_valid=0 immediately and counters 0. After release there is no dump until the next trigger.
